// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NR producers.
// Latency: one ARB cycle after req_valid, then one beat per cycle; one bubble cycle between bursts.
// Backpressure: fifo_full or clk_en low stalls the granted burst in place; the grant is never revoked.
// Optional source tag: define FIFO_WR_ARB_TAG_EN to prefix fifo_in with the requester index.
module fifo_wr_arb #(
  parameter int NR   = 4,
  parameter int DW   = 16,
  parameter int MAXB = 8,
  localparam int IW  = (NR > 1) ? $clog2(NR) : 1,
  localparam int CW  = (MAXB > 1) ? $clog2(MAXB) : 1,
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int OW  = DW + IW
`else
  localparam int OW  = DW
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [NR-1:0]    req_valid,
  input  logic [NR-1:0]    req_last,
  input  logic [NR*DW-1:0] req_data,
  output logic [NR-1:0]    req_ready,
  output logic [NR-1:0]    grant,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [OW-1:0]    fifo_in,
  output logic             busy
);

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

  state_t        state, state_nx;
  logic [NR-1:0] grant_q;
  logic [IW-1:0] gidx;     // index of the current owner, valid in BURST
  logic [IW-1:0] ptr;      // last owner; search starts just above it
  logic [IW-1:0] sel;
  logic [CW-1:0] cnt;      // beats already written in this burst
  logic          found;
  logic          xfer;
  logic          burst_end;
  logic [DW-1:0] data_sel;

  // Round-robin search: first valid requester starting at ptr+1, wrapping at NR.
  always_comb begin
    logic [IW:0] sum;
    found = 1'b0;
    sel   = '0;
    sum   = '0;
    for (int k = 1; k <= NR; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NR)) sum = sum - (IW+1)'(NR);
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        sel   = sum[IW-1:0];
      end
    end
  end

  // A beat moves only when the owner is valid, the FIFO has room and the clock is enabled.
  always_comb begin
    xfer      = clk_en && (state == BURST) && req_valid[gidx] && !fifo_full;
    burst_end = xfer && (req_last[gidx] || (cnt == CW'(MAXB - 1)));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= ARB;
    else if (clk_en) state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ARB:     if (found)     state_nx = BURST;
      BURST:   if (burst_end) state_nx = ARB;
      default:                state_nx = ARB;
    endcase
  end

  // Grant, owner index, RR pointer and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      gidx    <= '0;
      ptr     <= IW'(NR - 1);
      cnt     <= '0;
    end else if (clk_en) begin
      if (state == ARB) begin
        if (found) begin
          grant_q <= {{(NR-1){1'b0}}, 1'b1} << sel;
          gidx    <= sel;
          cnt     <= '0;
        end
      end else if (xfer) begin
        if (burst_end) begin
          ptr     <= gidx;
          grant_q <= '0;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Outputs: ready only to the owner, write strobe and data muxed from the owner.
  always_comb begin
    req_ready = '0;
    if ((state == BURST) && !fifo_full && clk_en) req_ready = grant_q;
    fifo_wr_en = xfer;
    data_sel   = req_data[int'(gidx)*DW +: DW];
`ifdef FIFO_WR_ARB_TAG_EN
    fifo_in    = {gidx, data_sel};
`else
    fifo_in    = data_sel;
`endif
    busy       = (state == BURST);
    grant      = grant_q;
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: producer queues per requester, a write log of the FIFO port,
// and hand-computed expected grants/data per cycle.
module tb_fifo_wr_arb;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MAXB = 8;
`ifdef FIFO_WR_ARB_TAG_EN
  localparam int OW = DW + 2;
`else
  localparam int OW = DW;
`endif

  logic clk = 1'b0;
  logic rst_n, clk_en, fifo_full;
  logic [NR-1:0] req_valid, req_last, req_ready, grant;
  logic [NR*DW-1:0] req_data;
  logic fifo_wr_en, busy;
  logic [OW-1:0] fifo_in;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] bd [NR][32];
  logic          bl [NR][32];
  int            hd [NR];
  int            tl [NR];
  logic [OW-1:0] wlog [$];
  logic [NR-1:0] take;

  logic [3:0]  eg [16] = '{4'h0,4'h1,4'h1,4'h0,4'h2,4'h2,4'h0,4'h4,4'h4,4'h0,4'h8,4'h8,4'h0,4'h1,4'h1,4'h0};
  logic [15:0] ed [16] = '{16'h00,16'h00,16'h01,16'h00,16'h10,16'h11,16'h00,16'h20,
                           16'h21,16'h00,16'h30,16'h31,16'h00,16'h02,16'h03,16'h00};

  always #5 clk = ~clk;

  fifo_wr_arb #(.NR(NR), .DW(DW), .MAXB(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .grant(grant),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_in(fifo_in), .busy(busy)
  );

  function automatic void refresh();
    for (int i = 0; i < NR; i++) begin
      if (hd[i] < tl[i]) begin
        req_valid[i] = 1'b1;
        req_last[i]  = bl[i][hd[i]];
        req_data[i*DW +: DW] = bd[i][hd[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endfunction

  task automatic push(input int r, input logic [DW-1:0] d, input logic l);
    bd[r][tl[r]] = d;
    bl[r][tl[r]] = l;
    tl[r] = tl[r] + 1;
    refresh();
  endtask

  // Handshake observed mid-cycle; accepted beats are popped just after the edge.
  always @(negedge clk) begin
    take = req_ready & req_valid;
    if (fifo_wr_en) wlog.push_back(fifo_in);
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int i = 0; i < NR; i++) if (take[i]) hd[i] = hd[i] + 1;
    end
    take = '0;
    refresh();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] logv(input int j);
    if (j < wlog.size()) return 32'(wlog[j]);
    return 32'hDEAD_DEAD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_en = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    refresh();
    tick();
    tick();
    rst_n = 1'b1;
    wlog.delete();
  endtask

  initial begin
    logic [3:0]  gx;
    logic        wx;
    logic [15:0] dx;
    logic [OW-1:0] tagx;
`ifdef FIFO_WR_ARB_TAG_EN
    tagx = {2'b11, 16'h1234};
`else
    tagx = 16'h1234;
`endif
    req_valid = '0; req_last = '0; req_data = '0; take = '0;
    rst_n = 1'b0; clk_en = 1'b1; fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin hd[i] = 0; tl[i] = 0; end
    #3;
    // Reset values
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single 3-beat burst from requester 0
    do_reset();
    push(0, 16'hA0, 1'b0); push(0, 16'hA1, 1'b0); push(0, 16'hA2, 1'b1);
    #1;
    chk("t1_arb_grant", 32'(grant), 0);
    chk("t1_arb_wr", 32'(fifo_wr_en), 0);
    tick();
    chk("t1_grant", 32'(grant), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(req_ready), 1);
    chk("t1_wr0", 32'(fifo_wr_en), 1);
    chk("t1_d0", 32'(fifo_in), 32'hA0);
    tick();
    chk("t1_d1", 32'(fifo_in), 32'hA1);
    tick();
    chk("t1_d2", 32'(fifo_in), 32'hA2);
    chk("t1_wr2", 32'(fifo_wr_en), 1);
    tick();
    chk("t1_end_grant", 32'(grant), 0);
    chk("t1_end_wr", 32'(fifo_wr_en), 0);
    chk("t1_log", 32'(wlog.size()), 3);

    // All four requesters, 2-beat bursts, requester 0 twice
    do_reset();
    for (int i = 0; i < NR; i++) begin
      push(i, 16'(i*16), 1'b0);
      push(i, 16'(i*16 + 1), 1'b1);
    end
    push(0, 16'h02, 1'b0); push(0, 16'h03, 1'b1);
    #1;
    for (int c = 0; c < 16; c++) begin
      chk("t2_grant", 32'(grant), 32'(eg[c]));
      chk("t2_wr", 32'(fifo_wr_en), 32'(eg[c] != 4'h0));
      if (eg[c] != 4'h0) chk("t2_data", 32'(fifo_in), 32'(ed[c]));
      tick();
    end
    chk("t2_log", 32'(wlog.size()), 10);

    // Requester 2 streams 20 beats, no last; requester 1 cuts in after the first 8
    do_reset();
    for (int k = 0; k < 20; k++) push(2, 16'(16'h200 + k), 1'b0);
    #1;
    for (int c = 0; c < 28; c++) begin
      if (c == 1) begin push(1, 16'h1AA, 1'b1); #1; end
      if (c == 0 || c == 9 || c == 11 || c == 20) gx = 4'h0;
      else if (c == 10) gx = 4'h2;
      else gx = 4'h4;
      wx = (gx != 4'h0) && (c <= 24);
      chk("t3_grant", 32'(grant), 32'(gx));
      chk("t3_wr", 32'(fifo_wr_en), 32'(wx));
      tick();
    end
    chk("t3_busy_held", 32'(busy), 1);
    chk("t3_log_n", 32'(wlog.size()), 21);
    for (int j = 0; j < 21; j++) begin
      if (j < 8) dx = 16'(16'h200 + j);
      else if (j == 8) dx = 16'h1AA;
      else dx = 16'(16'h200 + j - 1);
      chk("t3_log", logv(j), 32'(dx));
    end

    // fifo_full for 5 cycles mid-burst
    do_reset();
    for (int k = 0; k < 6; k++) push(0, 16'(16'h40 + k), k == 5);
    #1;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) begin fifo_full = 1'b1; #1; end
      if (c == 8) begin fifo_full = 1'b0; #1; end
      gx = (c == 0 || c == 12) ? 4'h0 : 4'h1;
      wx = (c >= 1 && c <= 2) || (c >= 8 && c <= 11);
      chk("t4_grant", 32'(grant), 32'(gx));
      chk("t4_wr", 32'(fifo_wr_en), 32'(wx));
      chk("t4_ready", 32'(req_ready), wx ? 32'h1 : 32'h0);
      if (wx) chk("t4_data", 32'(fifo_in), (c <= 2) ? 32'(16'h40 + c - 1) : 32'(16'h40 + c - 6));
      tick();
    end
    chk("t4_log_n", 32'(wlog.size()), 6);
    for (int j = 0; j < 6; j++) chk("t4_log", logv(j), 32'(16'h40 + j));

    // Asynchronous reset at beat 3
    do_reset();
    for (int k = 0; k < 6; k++) push(0, 16'(16'h50 + k), k == 5);
    push(1, 16'h60, 1'b1);
    #1;
    tick();
    chk("t5_d0", 32'(fifo_in), 32'h50);
    tick();
    tick();
    chk("t5_d2", 32'(fifo_in), 32'h52);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_ready", 32'(req_ready), 0);
    chk("t5_rst_wr", 32'(fifo_wr_en), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    tick();
    chk("t5_held_grant", 32'(grant), 0);
    rst_n = 1'b1;
    tick();
    chk("t5_regrant", 32'(grant), 1);
    chk("t5_resume", 32'(fifo_in), 32'h52);
    chk("t5_log_n", 32'(wlog.size()), 2);

    // clk_en gating and source tag on requester 3
    do_reset();
    clk_en = 1'b0;
    push(3, 16'h1234, 1'b1);
    #1;
    chk("t6_gate_ready", 32'(req_ready), 0);
    tick();
    tick();
    chk("t6_gate_grant", 32'(grant), 0);
    chk("t6_gate_busy", 32'(busy), 0);
    clk_en = 1'b1;
    tick();
    chk("t6_grant", 32'(grant), 32'h8);
    chk("t6_wr", 32'(fifo_wr_en), 1);
    chk("t6_tag", 32'(fifo_in), 32'(tagx));
    clk_en = 1'b0;
    #1;
    chk("t6_off_ready", 32'(req_ready), 0);
    chk("t6_off_wr", 32'(fifo_wr_en), 0);
    tick();
    chk("t6_off_grant", 32'(grant), 32'h8);
    chk("t6_off_busy", 32'(busy), 1);
    clk_en = 1'b1;
    #1;
    chk("t6_on_wr", 32'(fifo_wr_en), 1);
    tick();
    chk("t6_end_grant", 32'(grant), 0);
    chk("t6_log_n", 32'(wlog.size()), 1);
    chk("t6_log", logv(0), 32'(tagx));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
Name: fifo_wr_arb

Overview:
- Round-robin arbiter that shares the single write port of the dual-clock FIFO between NR producers, e.g. parallel Mandelbrot iteration engines emitting pixel results.
- Sits entirely in the FIFO's write clock domain and drives the FIFO's wr_en/in, honouring its full flag.
- Grants are burst-locked: a requester keeps the port until it signals last or hits a maximum burst length.

Parameters:
- NR, 4, number of requesters (2..16).
- DW, 16, data width per requester.
- MAXB, 8, maximum beats per grant before forced re-arbitration (1..256).
- IW, clog2(NR), requester index width (derived, localparam).

Ports:
- clk  in  1  write-domain clock (same clock as FIFO in_clk).
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  clock enable; when low, no state changes and no transfers.
- req_valid  in  NR  per-requester data valid.
- req_last  in  NR  per-requester end-of-burst marker, qualified by valid.
- req_data  in  NR*DW  packed data; requester i at [i*DW +: DW].
- req_ready  out  NR  per-requester accept.
- grant  out  NR  one-hot current owner, zero when idle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_in  out  OW  FIFO write data; OW = DW, or DW+IW with the tag feature.
- busy  out  1  high while a grant is held.

Behaviour:
- Reset values: grant = 0, req_ready = 0, fifo_wr_en = 0, busy = 0.
- Reset also sets state = ARB, beat counter = 0, and RR pointer = NR-1, so requester 0 has first priority.
- Transfer: occurs in a cycle when clk_en, state = BURST, req_valid[g] and !fifo_full, where g is the granted index.
  - req_ready[g] = state==BURST && !fifo_full && clk_en. All other req_ready are 0.
  - fifo_wr_en = req_ready[g] && req_valid[g], combinational.
  - fifo_in = req_data[g], combinational.
- State ARB:
  - If any req_valid is set, select the first set bit searching from pointer+1 upward, with wrap.
  - Register grant one-hot and go to BURST. The beat counter is cleared.
  - Arbitration latency is one cycle, so there are no transfers in the ARB cycle.
  - With no valid requests, stay in ARB with grant = 0.
- State BURST:
  - Each transfer increments the beat counter.
  - The burst ends on a transfer with req_last[g], or on a transfer when the beat count equals MAXB-1.
  - At burst end: pointer = g, grant cleared, state = ARB. There is exactly one bubble cycle between bursts.
- Boundary conditions:
  - fifo_full high: no transfer and no counter change. The grant is held indefinitely.
  - Granted requester drops valid mid-burst: grant is held and not revoked. Producers must not abandon a burst.
  - Single active requester: it is re-granted after each bubble cycle.
  - MAXB=1: every beat ends the grant.
  - req_last on a forced-end beat: the burst ends once; no special handling is needed.
  - clk_en low: all registers hold, and req_ready/fifo_wr_en are forced 0.
  - Asynchronous reset mid-burst: returns to the reset state immediately. A beat presented in the same cycle is not written.
- Ordering: beats of one grant reach the FIFO contiguously and in order. No beat is lost or duplicated.

Optional Feature:
- Macro: FIFO_WR_ARB_TAG_EN.
- Defined:
  - OW = DW+IW; fifo_in = {g[IW-1:0], req_data[g]}, so the read side can demultiplex by source.
  - The FIFO instance DW must be set to DW+IW.
- Undefined: OW = DW, fifo_in = req_data[g], and no index logic is generated.

Test Plan:
- Reset, then req_valid=4'b0001 with 3 beats 0xA0,0xA1,0xA2, last on the third -> grant=0001 one cycle after valid; three writes in consecutive cycles; grant=0 on the next cycle.
- All four requesters valid, each a 2-beat burst -> grant order 0,1,2,3,0; one idle cycle between bursts; FIFO contents grouped per requester in order.
- Requester 2 streams 20 beats without last, MAXB=8 -> grants of 8,8,4 beats; requester 1 with a pending request is granted after the first 8 beats.
- fifo_full asserted for 5 cycles mid-burst -> req_ready=0 and fifo_wr_en=0 throughout; grant held; burst resumes with no lost or duplicated data.
- rst_n pulsed low mid-burst at beat 3 -> outputs zero immediately; after release, requester 0 is granted first.
- FIFO_WR_ARB_TAG_EN defined, requester 3 writes 0x1234 -> fifo_in = {2'b11, 16'h1234}.
